lfsr_rng_gen: RTL and testbench



---
 rtl/lfsr_rng_gen.sv | 150 +++++++++++++++
 tb/tb_lfsr_rng_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_gen.sv
// Parametrised Fibonacci/Galois LFSR RNG: first word WARMUP+STEPS_PER_WORD edges after load, then one per STEPS_PER_WORD.
// Backpressure: a held word stalls the LFSR only on the step that would overwrite it; outputs are all registered.
module lfsr_rng_gen #(
    parameter int WIDTH          = 32,
    parameter int WARMUP         = 16,
    parameter int STEPS_PER_WORD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] poly_i,
    input  logic             mode_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] rnd_o,
    output logic             rnd_valid_o,
    input  logic             rnd_ready_i,
    output logic             running_o,
    output logic             zero_seed_o
);

    localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int SCW = (STEPS_PER_WORD > 1) ? $clog2(STEPS_PER_WORD) : 1;

    localparam logic [WCW-1:0]   WARM_INIT = WCW'(WARMUP);
    localparam logic [WCW-1:0]   WARM_ONE  = WCW'(1);
    localparam logic [SCW-1:0]   STEP_LAST = SCW'(STEPS_PER_WORD - 1);
    localparam logic [SCW-1:0]   STEP_ONE  = SCW'(1);
    localparam logic [WIDTH-1:0] LFSR_ONE  = WIDTH'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [1:0]       fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] poly_q, poly_d;
    logic             mode_q, mode_d;
    logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
    logic [SCW-1:0]   step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic             rnd_vld_q, rnd_vld_d;
    logic             running_q, running_d;
    logic             zero_seed_q, zero_seed_d;

    logic [WIDTH-1:0] lfsr_next;
    logic             in_warm;
    logic             in_run;
    logic             due;
    logic             stall;
    logic             advance;

    always_comb begin
        lfsr_next = lfsr_q;
        if (mode_q) begin
            lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? poly_q : '0);
        end else begin
            lfsr_next = {^(poly_q & lfsr_q), lfsr_q[WIDTH-1:1]};
        end
    end

    // Stall only when the step would overwrite a word nobody has taken yet.
    always_comb begin
        in_warm = (fsm_q == ST_WARMUP);
        in_run  = (fsm_q == ST_RUN);
        due     = (step_cnt_q == STEP_LAST);
        stall   = in_run & due & rnd_vld_q & ~rnd_ready_i;
        advance = enable_i & ~load_i & (in_warm | in_run) & ~stall;
    end

    always_comb begin
        fsm_d       = fsm_q;
        lfsr_d      = lfsr_q;
        poly_d      = poly_q;
        mode_d      = mode_q;
        warm_cnt_d  = warm_cnt_q;
        step_cnt_d  = step_cnt_q;
        rnd_d       = rnd_q;
        rnd_vld_d   = rnd_vld_q;
        zero_seed_d = 1'b0;

        if (load_i) begin
            poly_d     = poly_i;
            mode_d     = mode_i;
            warm_cnt_d = WARM_INIT;
            step_cnt_d = '0;
            rnd_vld_d  = 1'b0;
            fsm_d      = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            if (seed_i == '0) begin
                lfsr_d      = LFSR_ONE;
                zero_seed_d = 1'b1;
            end else begin
                lfsr_d = seed_i;
            end
        end else begin
            if (rnd_vld_q && rnd_ready_i) begin
                rnd_vld_d = 1'b0;
            end
            if (advance) begin
                lfsr_d = lfsr_next;
                if (in_warm) begin
                    warm_cnt_d = warm_cnt_q - WARM_ONE;
                    if (warm_cnt_q <= WARM_ONE) begin
                        fsm_d = ST_RUN;
                    end
                end else if (due) begin
                    rnd_d      = lfsr_next;
                    rnd_vld_d  = 1'b1;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q + STEP_ONE;
                end
            end
        end

        running_d = (fsm_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            lfsr_q      <= LFSR_ONE;
            poly_q      <= '0;
            mode_q      <= 1'b0;
            warm_cnt_q  <= '0;
            step_cnt_q  <= '0;
            rnd_q       <= '0;
            rnd_vld_q   <= 1'b0;
            running_q   <= 1'b0;
            zero_seed_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lfsr_q      <= lfsr_d;
            poly_q      <= poly_d;
            mode_q      <= mode_d;
            warm_cnt_q  <= warm_cnt_d;
            step_cnt_q  <= step_cnt_d;
            rnd_q       <= rnd_d;
            rnd_vld_q   <= rnd_vld_d;
            running_q   <= running_d;
            zero_seed_q <= zero_seed_d;
        end
    end

    assign rnd_o       = rnd_q;
    assign rnd_valid_o = rnd_vld_q;
    assign running_o   = running_q;
    assign zero_seed_o = zero_seed_q;

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Directed bench: three 4-bit instances (warm-up 2 / no warm-up / decimate-by-3) share stimulus.
module tb_lfsr_rng_gen;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] seed;
    logic [3:0] poly;
    logic       mode;
    logic       en;
    logic       rdy;

    logic [3:0] a_rnd, g_rnd, d_rnd;
    logic       a_vld, g_vld, d_vld;
    logic       a_run, g_run, d_run;
    logic       a_zs,  g_zs,  d_zs;

    int n_cmp;
    int n_err;

    // Fibonacci states from seed 0001 with taps 0011; index = steps taken since load.
    localparam logic [3:0] FIB [15] = '{
        4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011,
        4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011
    };
    localparam logic [3:0] GAL [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1101};

    lfsr_rng_gen #(.WIDTH(4), .WARMUP(2), .STEPS_PER_WORD(1)) dut_a (
        .clk(clk), .rst(rst), .load_i(load), .seed_i(seed), .poly_i(poly), .mode_i(mode),
        .enable_i(en), .rnd_o(a_rnd), .rnd_valid_o(a_vld), .rnd_ready_i(rdy),
        .running_o(a_run), .zero_seed_o(a_zs)
    );

    lfsr_rng_gen #(.WIDTH(4), .WARMUP(0), .STEPS_PER_WORD(1)) dut_g (
        .clk(clk), .rst(rst), .load_i(load), .seed_i(seed), .poly_i(poly), .mode_i(mode),
        .enable_i(en), .rnd_o(g_rnd), .rnd_valid_o(g_vld), .rnd_ready_i(rdy),
        .running_o(g_run), .zero_seed_o(g_zs)
    );

    lfsr_rng_gen #(.WIDTH(4), .WARMUP(2), .STEPS_PER_WORD(3)) dut_d (
        .clk(clk), .rst(rst), .load_i(load), .seed_i(seed), .poly_i(poly), .mode_i(mode),
        .enable_i(en), .rnd_o(d_rnd), .rnd_valid_o(d_vld), .rnd_ready_i(rdy),
        .running_o(d_run), .zero_seed_o(d_zs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] s, input logic [3:0] p, input logic m);
        load = 1'b1;
        seed = s;
        poly = p;
        mode = m;
        tick();
        load = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        load  = 1'b0;
        seed  = '0;
        poly  = '0;
        mode  = 1'b0;
        en    = 1'b1;
        rdy   = 1'b1;

        repeat (2) tick();
        chk("rst_rnd",  {60'd0, a_rnd}, 64'd0);
        chk("rst_vld",  {63'd0, a_vld}, 64'd0);
        chk("rst_run",  {63'd0, a_run}, 64'd0);
        chk("rst_zs",   {63'd0, a_zs},  64'd0);
        chk("rst_grun", {63'd0, g_run}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_vld", {63'd0, a_vld}, 64'd0);
        chk("idle_run", {63'd0, a_run}, 64'd0);

        // Fibonacci basic on dut_a, decimation on dut_d in parallel.
        do_load(4'b0001, 4'b0011, 1'b0);
        chk("fib_load_vld", {63'd0, a_vld}, 64'd0);
        chk("fib_load_run", {63'd0, a_run}, 64'd0);
        chk("fib_load_zs",  {63'd0, a_zs},  64'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("fib_vld_e%0d", k), {63'd0, a_vld}, {63'd0, (k >= 3)});
            chk($sformatf("fib_run_e%0d", k), {63'd0, a_run}, {63'd0, (k >= 2)});
            if (k >= 3) chk($sformatf("fib_rnd_e%0d", k), {60'd0, a_rnd}, {60'd0, FIB[k]});
            chk($sformatf("dec_vld_e%0d", k), {63'd0, d_vld}, {63'd0, (k == 5 || k == 8)});
            if (k >= 5) chk($sformatf("dec_rnd_e%0d", k), {60'd0, d_rnd}, {60'd0, (k < 8) ? FIB[5] : FIB[8]});
        end

        // Galois, no warm-up.
        do_load(4'b0001, 4'b1100, 1'b1);
        chk("gal_load_run", {63'd0, g_run}, 64'd1);
        chk("gal_load_vld", {63'd0, g_vld}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("gal_vld_%0d", k), {63'd0, g_vld}, 64'd1);
            chk($sformatf("gal_rnd_%0d", k), {60'd0, g_rnd}, {60'd0, GAL[k]});
        end

        // Backpressure on dut_a.
        do_load(4'b0001, 4'b0011, 1'b0);
        repeat (3) tick();
        chk("bp_first", {60'd0, a_rnd}, {60'd0, FIB[3]});
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_hold_rnd_%0d", k), {60'd0, a_rnd}, {60'd0, FIB[3]});
            chk($sformatf("bp_hold_vld_%0d", k), {63'd0, a_vld}, 64'd1);
        end
        rdy = 1'b1;
        tick();
        chk("bp_resume0", {60'd0, a_rnd}, {60'd0, FIB[4]});
        tick();
        chk("bp_resume1", {60'd0, a_rnd}, {60'd0, FIB[5]});

        // Zero seed, then enable dropped for 4 cycles.
        do_load(4'b0000, 4'b0011, 1'b0);
        chk("zs_pulse_a", {63'd0, a_zs}, 64'd1);
        chk("zs_pulse_d", {63'd0, d_zs}, 64'd1);
        tick();
        chk("zs_clear", {63'd0, a_zs}, 64'd0);
        repeat (3) tick();
        chk("zs_rnd_e4", {60'd0, a_rnd}, {60'd0, FIB[4]});
        en = 1'b0;
        for (int k = 5; k <= 8; k++) begin
            tick();
            chk($sformatf("en_hold_rnd_e%0d", k), {60'd0, a_rnd}, {60'd0, FIB[4]});
            chk($sformatf("en_hold_vld_e%0d", k), {63'd0, a_vld}, 64'd0);
            chk($sformatf("en_hold_dvld_e%0d", k), {63'd0, d_vld}, 64'd0);
        end
        en = 1'b1;
        for (int k = 9; k <= 12; k++) begin
            tick();
            chk($sformatf("en_res_rnd_e%0d", k), {60'd0, a_rnd}, {60'd0, FIB[k - 4]});
            chk($sformatf("en_res_dvld_e%0d", k), {63'd0, d_vld}, {63'd0, (k == 9 || k == 12)});
        end
        chk("en_res_drnd", {60'd0, d_rnd}, {60'd0, FIB[8]});

        // Reload while a word is held, then reload over a handshake.
        do_load(4'b0001, 4'b0011, 1'b0);
        repeat (3) tick();
        rdy = 1'b0;
        tick();
        chk("rl_held", {63'd0, a_vld}, 64'd1);
        do_load(4'b0001, 4'b0011, 1'b0);
        chk("rl_vld_drop", {63'd0, a_vld}, 64'd0);
        chk("rl_warm", {63'd0, a_run}, 64'd0);
        tick();
        chk("rl_e1_vld", {63'd0, a_vld}, 64'd0);
        tick();
        chk("rl_e2_run", {63'd0, a_run}, 64'd1);
        rdy = 1'b1;
        tick();
        chk("rl_e3_rnd", {60'd0, a_rnd}, {60'd0, FIB[3]});
        chk("rl_e3_vld", {63'd0, a_vld}, 64'd1);
        do_load(4'b1000, 4'b0011, 1'b0);
        chk("rl_hs_vld", {63'd0, a_vld}, 64'd0);
        tick();

        // Asynchronous reset during warm-up.
        rst = 1'b1;
        #1;
        chk("arst_rnd",  {60'd0, a_rnd}, 64'd0);
        chk("arst_vld",  {63'd0, a_vld}, 64'd0);
        chk("arst_run",  {63'd0, a_run}, 64'd0);
        chk("arst_zs",   {63'd0, a_zs},  64'd0);
        chk("arst_grun", {63'd0, g_run}, 64'd0);
        chk("arst_grnd", {60'd0, g_rnd}, 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_vld_%0d", k), {63'd0, a_vld}, 64'd0);
            chk($sformatf("post_rst_grun_%0d", k), {63'd0, g_run}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
